// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the iterative multiply sequencer: FSM state encoding
// and the RV32M multiply funct3 codes.
package mul_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Radix-2 shift-add datapath: holds the multiplicand, a shifting multiplier and
// the 2*WIDTH accumulator; advanced one bit per step strobe.
module mul_shift_add_dp #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_mcand,
    input  logic [WIDTH-1:0]   i_mplier,
    output logic [2*WIDTH-1:0] o_product_next
);

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_unused_lsb;

    // The adder carry becomes the new MSB as the accumulator shifts right.
    always_comb begin
        w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
        w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_load) begin
            r_mcand  <= i_mcand;
            r_mplier <= i_mplier;
            r_acc    <= '0;
        end else if (i_step) begin
            r_mplier <= r_mplier >> 1;
            r_acc    <= w_acc_next;
        end
    end

    assign w_unused_lsb   = r_acc[0];
    assign o_product_next = w_acc_next;

endmodule

// File: rtl/mul_sequencer.sv
// Iterative WIDTH x WIDTH multiply controller that stalls the core while a
// shift-add runs. Define MUL_HIGH_EN for MULH/MULHSU/MULHU support.
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] rs1_data_i,
    input  logic [WIDTH-1:0] rs2_data_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mul_state_e         r_state;
    mul_state_e         w_next_state;
    logic [CNT_W-1:0]   r_count;
    logic               w_load;
    logic               w_step;
    logic               w_finish;
    logic [WIDTH-1:0]   w_mcand;
    logic [WIDTH-1:0]   w_mplier;
    logic [WIDTH-1:0]   w_final;
    logic [WIDTH-1:0]   r_result;
    logic [2*WIDTH-1:0] w_product_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (start_i) w_next_state = RUN;
            RUN: begin
                if (!start_i) begin
                    w_next_state = IDLE;
                end else if (r_count == CNT_LAST) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Stall is combinational so the PC freezes in the cycle the multiply appears.
    always_comb begin
        w_load   = (r_state == IDLE) && start_i;
        w_step   = (r_state == RUN) && start_i;
        w_finish = w_step && (r_count == CNT_LAST);
        done_o   = (r_state == DONE);
        stall_o  = start_i && (r_state != DONE) && !reset;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_load) begin
            r_count <= '0;
        end else if (w_step) begin
            r_count <= r_count + 1'b1;
        end
    end

    mul_shift_add_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk           (clk),
        .reset         (reset),
        .i_load        (w_load),
        .i_step        (w_step),
        .i_mcand       (w_mcand),
        .i_mplier      (w_mplier),
        .o_product_next(w_product_next)
    );

`ifdef MUL_HIGH_EN
    logic               r_negate;
    logic [2:0]         r_funct3;
    logic               w_rs1_neg;
    logic               w_rs2_neg;
    logic [2*WIDTH-1:0] w_fixed;

    // Signed operands are multiplied as magnitudes; the sign is restored afterwards.
    always_comb begin
        w_rs1_neg = rs1_data_i[WIDTH-1] && ((funct3_i == F3_MULH) || (funct3_i == F3_MULHSU));
        w_rs2_neg = rs2_data_i[WIDTH-1] && (funct3_i == F3_MULH);
        w_mcand   = w_rs1_neg ? -rs1_data_i : rs1_data_i;
        w_mplier  = w_rs2_neg ? -rs2_data_i : rs2_data_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_funct3 <= F3_MUL;
            r_negate <= 1'b0;
        end else if (w_load) begin
            r_funct3 <= funct3_i;
            r_negate <= w_rs1_neg ^ w_rs2_neg;
        end
    end

    always_comb begin
        w_fixed = r_negate ? -w_product_next : w_product_next;
        case (r_funct3)
            F3_MUL:                       w_final = w_fixed[WIDTH-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: w_final = w_fixed[2*WIDTH-1:WIDTH];
            default:                      w_final = '0;
        endcase
    end
`else
    logic w_unused_bits;

    assign w_mcand       = rs1_data_i;
    assign w_mplier      = rs2_data_i;
    assign w_final       = w_product_next[WIDTH-1:0];
    assign w_unused_bits = ^{funct3_i, w_product_next[2*WIDTH-1:WIDTH]};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= '0;
        end else if (w_finish) begin
            r_result <= w_final;
        end
    end

    assign result_o = r_result;

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: stimulus pushes expected products, a
// negedge monitor pops and compares whenever done_o is seen.
`timescale 1ns/1ps
module tb_mul_sequencer;

    localparam int WIDTH   = 32;
    localparam int LATENCY = WIDTH + 1;
    localparam int TIMEOUT = 200;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic        start_i    = 1'b0;
    logic [2:0]  funct3_i   = 3'b000;
    logic [31:0] rs1_data_i = 32'h0;
    logic [31:0] rs2_data_i = 32'h0;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cycleNo     = 0;
    logic [31:0] expQ[$];
    string       nameQ[$];
    logic [31:0] lastResult  = 32'h0;

    mul_sequencer #(
        .WIDTH(WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_i   (start_i),
        .funct3_i  (funct3_i),
        .rs1_data_i(rs1_data_i),
        .rs2_data_i(rs2_data_i),
        .stall_o   (stall_o),
        .done_o    (done_o),
        .result_o  (result_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleNo <= cycleNo + 1;

    // Reference: extend operands to 64 bits per signedness and multiply directly.
    function automatic logic [31:0] refMul(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
`ifdef MUL_HIGH_EN
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        if (f3[2]) return 32'h0;
        ea = {32'h0, a};
        eb = {32'h0, b};
        if (f3 == 3'b001 || f3 == 3'b010) ea = {{32{a[31]}}, a};
        if (f3 == 3'b001) eb = {{32{b[31]}}, b};
        p = ea * eb;
        return (f3 == 3'b000) ? p[31:0] : p[63:32];
`else
        logic [2:0] ignored;
        ignored = f3;
        return (ignored == 3'b000 || ignored != 3'b000) ? a * b : 32'h0;
`endif
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    // Issues one multiply, checks stall/latency; the monitor checks the product.
    task automatic applyStimulus(string name, logic [2:0] f3, logic [31:0] a, logic [31:0] b,
                                 logic [31:0] expected, bit holdAfter, output int doneCycle);
        int  cyc;
        int  stallCount;
        bit  seen;
        @(negedge clk);
        start_i    = 1'b1;
        funct3_i   = f3;
        rs1_data_i = a;
        rs2_data_i = b;
        expQ.push_back(expected);
        nameQ.push_back(name);
        cyc        = 0;
        stallCount = 0;
        seen       = 1'b0;
        doneCycle  = -1;
        while (!seen && cyc < TIMEOUT) begin
            #1;
            if (done_o) begin
                seen      = 1'b1;
                doneCycle = cycleNo;
            end else begin
                if (stall_o) stallCount++;
                cyc++;
                if (cyc == 2) begin
                    rs1_data_i = $urandom;
                    rs2_data_i = $urandom;
                    funct3_i   = 3'($urandom_range(0, 7));
                end
                @(negedge clk);
            end
        end
        checkOutput({name, "_latency"}, 32'(cyc), 32'(LATENCY));
        checkOutput({name, "_stall_cycles"}, 32'(stallCount), 32'(LATENCY));
        checkOutput({name, "_stall_at_done"}, {31'h0, stall_o}, 32'h0);
        if (!holdAfter) start_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && done_o) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_done: got result %h, want no completion", result_o);
            end else begin
                logic [31:0] e;
                string       n;
                e = expQ.pop_front();
                n = nameQ.pop_front();
                checkOutput(n, result_o, e);
                lastResult = e;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got still running, want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d1;
        int d2;
        int doneCount;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;

        #2 reset = 1'b1;
        #1;
        checkOutput("reset_result", result_o, 32'h0);
        checkOutput("reset_done", {31'h0, done_o}, 32'h0);
        checkOutput("reset_stall", {31'h0, stall_o}, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        applyStimulus("basic_mul", 3'b000, 32'd7, 32'd6, 32'd42, 1'b0, d1);
        applyStimulus("wrap_mul", 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, d1);
`ifdef MUL_HIGH_EN
        applyStimulus("wrap_mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, d1);
        applyStimulus("wrap_mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, d1);
        applyStimulus("mulhsu_neg", 3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, d1);
        applyStimulus("mulh_minneg", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, d1);
        applyStimulus("div_space", 3'b100, 32'd9, 32'd9, 32'h0, 1'b0, d1);
`endif

        applyStimulus("b2b_first", 3'b000, 32'd3, 32'd5, 32'd15, 1'b1, d1);
        applyStimulus("b2b_second", 3'b000, 32'd4, 32'd4, 32'd16, 1'b0, d2);
        checkOutput("b2b_spacing", 32'(d2 - d1), 32'(WIDTH + 2));

        // Abort at RUN cycle 10: no completion, result unchanged.
        @(negedge clk);
        start_i    = 1'b1;
        funct3_i   = 3'b000;
        rs1_data_i = 32'd1000;
        rs2_data_i = 32'd1000;
        repeat (10) @(negedge clk);
        start_i = 1'b0;
        #1;
        checkOutput("abort_stall", {31'h0, stall_o}, 32'h0);
        doneCount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (done_o) doneCount++;
        end
        checkOutput("abort_no_done", 32'(doneCount), 32'h0);
        checkOutput("abort_result_kept", result_o, lastResult);

        // Reset asserted asynchronously at RUN cycle 20.
        @(negedge clk);
        start_i    = 1'b1;
        rs1_data_i = 32'd12345;
        rs2_data_i = 32'd678;
        repeat (20) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_stall", {31'h0, stall_o}, 32'h0);
        checkOutput("midrst_done", {31'h0, done_o}, 32'h0);
        checkOutput("midrst_result", result_o, 32'h0);
        lastResult = 32'h0;
        @(negedge clk);
        reset   = 1'b0;
        start_i = 1'b0;
        applyStimulus("after_reset", 3'b000, 32'd2, 32'd3, 32'd6, 1'b0, d1);

        for (int i = 0; i < 24; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = pickOperand();
            b  = pickOperand();
            applyStimulus("rand_mul", f3, a, b, refMul(f3, a, b),
                          (i != 23) && ($urandom_range(0, 1) == 1), d1);
        end

        repeat (5) @(negedge clk);
        checkOutput("queue_drained", 32'(expQ.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
